// File: rtl/nsc8_pkg.sv
// Shared NSC8 definitions: default data width, derived address width and image size,
// and the program loader state enumeration.
package nsc8_pkg;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = DATA_W / 2;
  localparam int IMAGE_WORDS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SUM,
    DRAIN,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM store port of the program loader, bundled with
// master (loader) and slave (source/RAM side) modports.
interface program_loader_if #(
  parameter int N = 8
);
  localparam int AW = N / 2;

  // Handshake: rx_data moves on a rising clock edge where rx_valid and rx_ready are
  // both high. rx_ready depends only on loader state, never on rx_valid. rx_data is
  // ignored whenever rx_valid is low, and rx_valid while rx_ready is low does nothing.
  logic [N-1:0]  rx_data;
  logic          rx_valid;
  logic          rx_ready;

  logic [AW-1:0] ram_address;
  logic [N-1:0]  ram_data;
  logic          ram_store;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, ram_address, ram_data, ram_store
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, ram_address, ram_data, ram_store
  );

endinterface

// File: rtl/loader_checksum.sv
// N-bit running-sum accumulator for the program loader: clear, add a byte, and test
// whether the sum plus the current byte wraps to zero.
module loader_checksum #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         add,
  input  logic [N-1:0] data,
  output logic         zero_o
);

  logic [N-1:0] sum_q;
  logic [N-1:0] sum_d;
  logic [N-1:0] sum_plus;

  assign sum_plus = sum_q + data;
  assign zero_o   = (sum_plus == '0);

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = sum_plus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// NSC8 program loader: writes a byte stream to RAM words 0..2^(N/2)-1 while holding
// the core in reset. Define LOADER_CHECKSUM_EN to require a trailing checksum byte.
module program_loader
  import nsc8_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic             clk,
  input  logic             reset_loader,
  input  logic             start,
  program_loader_if.master bus,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_error,
  output loader_state_t    dbg_state
);

  localparam int AW = N / 2;
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  loader_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          store_q, store_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [N-1:0]  data_q, data_d;

  logic rx_ready;
  logic xfer;
  logic start_accept;
  logic load_xfer;
  logic sum_zero;

  assign xfer         = bus.rx_valid & rx_ready;
  assign load_xfer    = xfer & (state_q == LOAD);
  assign start_accept = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERROR));

`ifdef LOADER_CHECKSUM_EN
  loader_checksum #(.N(N)) u_checksum (
    .clk    (clk),
    .rst    (reset_loader),
    .clear  (start_accept),
    .add    (load_xfer),
    .data   (bus.rx_data),
    .zero_o (sum_zero)
  );
`else
  assign sum_zero = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset_loader) begin
      state_q <= IDLE;
      idx_q   <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (xfer && (idx_q == LAST_IDX)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = SUM;
`else
          state_d = DRAIN;
`endif
        end
      end
      SUM: begin
        if (xfer) state_d = sum_zero ? DONE : ERROR;
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (start) state_d = LOAD;
      end
      ERROR: begin
        if (start) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Store pipeline: a LOAD transfer becomes a one-cycle strobe in the following cycle;
  // address and data hold between strobes. The checksum byte taken in SUM is never stored.
  always_comb begin
    idx_d   = idx_q;
    store_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (start_accept) begin
      idx_d = '0;
    end
    if (load_xfer) begin
      store_d = 1'b1;
      addr_d  = idx_q;
      data_d  = bus.rx_data;
      if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
    end
  end

  always_comb begin
    rx_ready  = 1'b0;
    cpu_hold  = 1'b0;
    load_done = 1'b0;
    case (state_q)
      LOAD: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      SUM: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      DRAIN: begin
        cpu_hold = 1'b1;
      end
      DONE: begin
        load_done = 1'b1;
      end
      ERROR: begin
        cpu_hold = 1'b1;
      end
      default: begin
        rx_ready = 1'b0;
      end
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  assign load_error = (state_q == ERROR);
`else
  assign load_error = 1'b0;
`endif

  assign bus.rx_ready    = rx_ready;
  assign bus.ram_store   = store_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data    = data_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized byte streams checked against a
// session-level reference model and a store scoreboard.
module tb_program_loader;
  import nsc8_pkg::*;

  localparam int N     = 8;
  localparam int WORDS = 16;

  logic clk = 1'b0;
  logic reset_loader = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, load_done, load_error;
  loader_state_t dbg_state;

  program_loader_if #(.N(N)) bus ();

  program_loader #(.N(N)) dut (
    .clk          (clk),
    .reset_loader (reset_loader),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a session takes WORDS data bytes (plus a checksum byte when
  // enabled); afterwards one drain cycle, then done or error.
  bit         m_active = 0, m_drain = 0, m_done = 0, m_err = 0;
  int         m_count = 0;
  logic [7:0] m_sum = '0;
  logic [3:0] last_a = '0;
  logic [7:0] last_d = '0;
  logic [7:0] exp_img [WORDS];
  logic [7:0] obs_img [WORDS];
  logic [11:0] exp_q[$];
  int          due_q[$];
  logic [11:0] mon_e;
  logic [7:0]  stim_q[$];

  int  tests_run = 0;
  int  tests_failed = 0;
  bit  mon_en = 0;

  task automatic tick(input bit rst, input bit st, input bit v, input logic [7:0] d);
    bit n_active, n_drain, n_done, n_err, xfer;
    int n_count;
    logic [7:0] n_sum;
    reset_loader = rst;
    start = st;
    bus.rx_valid = v;
    bus.rx_data = d;
    n_active = m_active; n_drain = m_drain; n_done = m_done; n_err = m_err;
    n_count = m_count; n_sum = m_sum;
    xfer = v && m_active;
    if (rst) begin
      n_active = 0; n_drain = 0; n_done = 0; n_err = 0; n_count = 0; n_sum = '0;
    end else if (!m_active && !m_drain && st) begin
      n_active = 1; n_done = 0; n_err = 0; n_count = 0; n_sum = '0;
    end else if (m_drain) begin
      n_drain = 0; n_done = 1;
    end else if (xfer) begin
      if (m_count < WORDS) begin
        exp_q.push_back({4'(m_count), d});
        due_q.push_back(cyc + 1);
        exp_img[m_count] = d;
        n_sum = m_sum + d;
        n_count = m_count + 1;
`ifndef LOADER_CHECKSUM_EN
        if (n_count == WORDS) begin
          n_active = 0; n_drain = 1;
        end
`endif
      end else begin
        n_active = 0;
        if (8'(m_sum + d) == 8'h00) n_done = 1;
        else n_err = 1;
      end
    end
    @(posedge clk);
    m_active = n_active; m_drain = n_drain; m_done = n_done; m_err = n_err;
    m_count = n_count; m_sum = n_sum;
    if (rst) begin
      last_a = '0; last_d = '0;
    end
    #1;
  endtask

  // Scoreboard: every cycle checks the store port and the control outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      tests_run++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        mon_e = exp_q.pop_front();
        void'(due_q.pop_front());
        if (bus.ram_store !== 1'b1 || bus.ram_address !== mon_e[11:8] || bus.ram_data !== mon_e[7:0]) begin
          tests_failed++;
          $display("FAIL store cyc=%0d: got st=%0b a=%0h d=%0h, expected st=1 a=%0h d=%0h",
                   cyc, bus.ram_store, bus.ram_address, bus.ram_data, mon_e[11:8], mon_e[7:0]);
        end else begin
          obs_img[bus.ram_address] = bus.ram_data;
        end
        last_a = mon_e[11:8];
        last_d = mon_e[7:0];
      end else if (bus.ram_store !== 1'b0 || bus.ram_address !== last_a || bus.ram_data !== last_d) begin
        tests_failed++;
        $display("FAIL idle_store cyc=%0d: got st=%0b a=%0h d=%0h, expected st=0 a=%0h d=%0h",
                 cyc, bus.ram_store, bus.ram_address, bus.ram_data, last_a, last_d);
      end
      tests_run++;
      if ({bus.rx_ready, cpu_hold, load_done, load_error} !==
          {m_active, m_active | m_drain | m_err, m_done, m_err}) begin
        tests_failed++;
        $display("FAIL control cyc=%0d: got rdy/hold/done/err=%b, expected %b", cyc,
                 {bus.rx_ready, cpu_hold, load_done, load_error},
                 {m_active, m_active | m_drain | m_err, m_done, m_err});
      end
    end
  end

  // kind 0: base+i, kind 1: random, kind 2: all 0x01; bad=1 corrupts the checksum byte.
  task automatic build_stream(input int kind, input logic [7:0] base, input bit bad);
    logic [7:0] b, s;
    s = '0;
    stim_q.delete();
    for (int i = 0; i < WORDS; i++) begin
      if (kind == 0) b = base + 8'(i);
      else if (kind == 1) b = 8'($urandom_range(0, 255));
      else b = 8'h01;
      stim_q.push_back(b);
      s = s + b;
    end
`ifdef LOADER_CHECKSUM_EN
    stim_q.push_back(8'(0 - s) + (bad ? 8'h01 : 8'h00));
`else
    if (bad) stim_q.push_back(8'h00);
`endif
  endtask

  // gap 0: back-to-back, 1: valid toggles every cycle, 2: random idle gaps.
  task automatic send_stream(input int gap, input int count, input bit st);
    for (int i = 0; i < count && i < stim_q.size(); i++) begin
      if (gap == 1 && i > 0) tick(0, st, 0, 8'($urandom_range(0, 255)));
      if (gap == 2) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick(0, st, 0, 8'($urandom_range(0, 255)));
      end
      tick(0, st, 1, stim_q[i]);
    end
  endtask

  task automatic begin_session(input bit with_valid);
    tick(0, 1, with_valid, 8'($urandom_range(0, 255)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 8'h00);
    mon_en = 1;
    tick(1, 0, 0, 8'h00);
    tick(0, 0, 1, 8'hA5);
    tests_run++;
    if ({bus.rx_ready, bus.ram_store, cpu_hold, load_done, load_error} !== 5'b0 ||
        bus.ram_address !== 4'h0 || bus.ram_data !== 8'h00 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy/st/hold/done/err=%b a=%0h d=%0h, expected all 0",
               {bus.rx_ready, bus.ram_store, cpu_hold, load_done, load_error},
               bus.ram_address, bus.ram_data);
    end
  endtask

  task automatic check_done_image(input string name);
    tests_run++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_done: got done=%0b hold=%0b err=%0b, expected done=1 hold=0 err=0",
               name, load_done, cpu_hold, load_error);
    end
    for (int i = 0; i < WORDS; i++) begin
      tests_run++;
      if (obs_img[i] !== exp_img[i]) begin
        tests_failed++;
        $display("FAIL %s_image[%0d]: got %0h, expected %0h", name, i, obs_img[i], exp_img[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    build_stream(0, 8'h10, 0);
    begin_session(1);
    send_stream(0, stim_q.size(), 0);
    idle(3);
    check_done_image("back_to_back");
  endtask

  task automatic test_toggle_valid();
    build_stream(1, 8'h00, 0);
    begin_session(0);
    send_stream(1, stim_q.size(), 0);
    idle(3);
    check_done_image("toggle_valid");
  endtask

  task automatic test_random_sessions();
    for (int s = 0; s < 4; s++) begin
      build_stream(1, 8'h00, 0);
      begin_session($urandom_range(0, 1));
      send_stream(2, stim_q.size(), 0);
      idle($urandom_range(2, 4));
      check_done_image("random");
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    build_stream(2, 8'h00, 0);
    begin_session(0);
    send_stream(0, stim_q.size(), 0);
    idle(2);
    check_done_image("checksum_ok");
    build_stream(2, 8'h00, 1);
    begin_session(0);
    send_stream(0, stim_q.size(), 0);
    idle(3);
    tests_run++;
    if (load_error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL checksum_bad: got err=%0b hold=%0b done=%0b, expected err=1 hold=1 done=0",
               load_error, cpu_hold, load_done);
    end
    build_stream(1, 8'h00, 0);
    begin_session(0);
    send_stream(2, stim_q.size(), 0);
    idle(2);
    check_done_image("checksum_recover");
  endtask
`endif

  task automatic test_reset_mid();
    build_stream(1, 8'h00, 0);
    begin_session(0);
    send_stream(0, 5, 0);
    tick(1, 0, 1, 8'h5A);
    tests_run++;
    if ({bus.rx_ready, bus.ram_store, cpu_hold, load_done, load_error} !== 5'b0 ||
        bus.ram_address !== 4'h0 || bus.ram_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid: got rdy/st/hold/done/err=%b a=%0h d=%0h, expected all 0",
               {bus.rx_ready, bus.ram_store, cpu_hold, load_done, load_error},
               bus.ram_address, bus.ram_data);
    end
    idle(2);
    build_stream(1, 8'h00, 0);
    begin_session(0);
    send_stream(0, stim_q.size(), 0);
    idle(3);
    check_done_image("reset_mid");
  endtask

  task automatic test_start_held();
    build_stream(1, 8'h00, 0);
    begin_session(0);
    send_stream(2, stim_q.size(), 1);
    tick(0, 1, 0, 8'h00);
    tick(0, 1, 0, 8'h00);
    tick(0, 1, 0, 8'h00);
    tests_run++;
    if (bus.rx_ready !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_held_restart: got rdy=%0b hold=%0b done=%0b, expected rdy=1 hold=1 done=0",
               bus.rx_ready, cpu_hold, load_done);
    end
    build_stream(0, 8'hC0, 0);
    send_stream(0, stim_q.size(), 0);
    idle(3);
    check_done_image("start_held");
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      exp_img[i] = '0;
      obs_img[i] = '0;
    end
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_random_sessions();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    test_start_held();
    idle(2);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL pending_stores: got %0d unconsumed, expected 0", exp_q.size());
    end
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader for the NSC8 core; the write-side counterpart to the core's RAM fetch path. It accepts one byte per valid/ready handshake and writes the bytes in order to RAM addresses 0 to 2^(N/2)-1 through the RAM store port. While it writes, it holds the core in reset, and it releases the core once the full image is written. It sits beside `ram` on the `clk_decode` domain and drives the core's reset/clear inputs through `cpu_hold`.

## Interface
- `N`, default 8: data width; address width is N/2, image size is 2^(N/2) words (16 for N=8).
- `clk`  in  1  clock (same clock as the RAM store port).
- `reset_loader`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a load session; ignored in LOAD, SUM, DRAIN.
- `rx_data`  in  N  incoming program byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte; a transfer occurs on a rising edge with `rx_valid & rx_ready`.
- `ram_address`  out  N/2  RAM write address.
- `ram_data`  out  N  RAM write data.
- `ram_store`  out  1  one-cycle RAM write strobe.
- `cpu_hold`  out  1  high while loading; drives the core's `reset_counter`, `reset_ring` and `clear_ir`.
- `load_done`  out  1  image fully written; level signal.
- `load_error`  out  1  checksum mismatch; level signal (constant 0 when the checksum is compiled out).

## Operation
- FSM states: IDLE, LOAD, SUM, DRAIN, DONE, ERROR.
- IDLE:
  - All outputs 0.
  - `start` → LOAD.
- LOAD:
  - `rx_ready=1`, `cpu_hold=1`.
  - Each transfer registers (word index, `rx_data`) into the store pipeline.
  - The word index is an N/2-bit counter, cleared on entry to LOAD.
  - The transfer at index 2^(N/2)-1 goes to SUM if `LOADER_CHECKSUM_EN` is defined, else to DRAIN.
- SUM:
  - `rx_ready=1`, `cpu_hold=1`.
  - On the next transfer: if (running sum + `rx_data`) mod 2^N == 0 → DONE, else → ERROR.
  - The checksum byte is never written to RAM.
- DRAIN:
  - `rx_ready=0`, `cpu_hold=1`.
  - Lasts exactly one cycle; the last store completes here. Then → DONE.
- DONE:
  - `load_done=1`, `cpu_hold=0`, `rx_ready=0`.
  - `start` → LOAD (reload, counter and sum cleared).
- ERROR:
  - `load_error=1`, `cpu_hold=1`, `rx_ready=0`.
  - `start` → LOAD (fresh); otherwise stays in ERROR until reset.
- Running sum: N bits, wraps mod 2^N, cleared on entry to LOAD, adds every data byte.
- The word counter never wraps during a session; the state exits exactly at the last index.
- `rx_valid` without `rx_ready` has no effect.
- `rx_data` is a don't-care when `rx_valid=0`.

## Timing
- Reset state:
  - State IDLE.
  - `rx_ready`, `ram_store`, `cpu_hold`, `load_done`, `load_error` all 0.
  - `ram_address`, `ram_data`, counter and sum all 0.
- Store latency:
  - A transfer at edge k gives `ram_store=1` with the matching `ram_address`/`ram_data` during cycle k+1.
  - Back-to-back transfers give back-to-back stores at full rate of 1 byte/cycle.
- `ram_store` is never high two cycles for one byte.
- `ram_address`/`ram_data` hold their last value when `ram_store=0`.
- `cpu_hold` rises in the first LOAD cycle, one cycle after `start` is sampled in IDLE or DONE.
- `cpu_hold` falls in the first DONE cycle, which is always after the final `ram_store` cycle.
- `start` and `rx_valid` in the same IDLE cycle: only the state changes; `rx_ready` is 0 in that cycle, so no byte is taken.
- `reset_loader` mid-session: returns to IDLE next edge and any pending store is dropped (`ram_store=0`). A partial image is possible; the system reset is responsible for the core.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The SUM state is present.
  - The stream is 2^(N/2)+1 bytes, the last being the two's-complement checksum.
  - A mismatch → ERROR with `cpu_hold` held high.
- `LOADER_CHECKSUM_EN` undefined:
  - No SUM or ERROR behaviour; the stream is exactly 2^(N/2) bytes.
  - The last data transfer → DRAIN → DONE.
  - `load_error` is tied to 0.

## Structure
- Shared package `nsc8_pkg`:
  - `loader_state_t` enum (IDLE, LOAD, SUM, DRAIN, DONE, ERROR).
  - `ADDR_W = N/2`.
  - `IMAGE_WORDS = 2**ADDR_W`.
- One sub-module is natural: `loader_checksum`, the N-bit running-sum accumulator with clear/add/check. It is instantiated only under `LOADER_CHECKSUM_EN`.
- FSM, counter and store pipeline are inline.

## Test plan
- Reset, then `start`, then 16 bytes 0x10..0x1F back-to-back (macro off):
  - 16 consecutive `ram_store` pulses at addresses 0..15 with data 0x10..0x1F.
  - `cpu_hold` high from the cycle after `start` until the DONE cycle.
  - `load_done=1` afterwards.
- `rx_valid` toggled 1/0 every cycle while loading:
  - Stores occur only one cycle after each transfer.
  - No duplicate or missing address.
- Macro on, bytes 0x01 ×16 then checksum 0xF0:
  - DONE, `load_error=0`, `cpu_hold=0`.
  - Repeat with checksum 0xF1 → ERROR, `load_error=1`, `cpu_hold=1`.
  - Then `start` plus a correct stream → DONE.
- `reset_loader` asserted after 5 bytes:
  - Next cycle IDLE with all outputs 0.
  - A new `start` rewrites from address 0.
- `start` pulsed during LOAD and held through DONE:
  - Ignored during LOAD.
  - In DONE it restarts a fresh session (`load_done` drops, `cpu_hold` rises next cycle).
